instr_mem_ctrl: RTL
===================

# instr_mem_ctrl

Two-port instruction memory controller: replaces the single-port instruction RAM/boot-ROM wrapper with a word-interleaved, N-bank RAM, a wait-state-capable boot ROM port, and a req/gnt/rvalid handshake on both ports. The core fetch port and the loader (debug/AXI-bridge) port access different banks in parallel. Bank conflicts are arbitrated with loader priority. Sits between the core instruction interface and the boot ROM macro in the MCU top level.

## Interface

- RAM_SIZE, 32768, RAM bytes; power of two
- DATA_WIDTH, 32, word width; only 32 supported
- N_BANKS, 2, RAM banks; power of two, 1..8
- ROM_ADDR_WIDTH, 12, ROM byte-address width (ROM is 2^ROM_ADDR_WIDTH bytes)
- ROM_WAIT, 1, extra ROM read wait cycles, 0..7
- ADDR_WIDTH, $clog2(RAM_SIZE)+1, byte address; MSB=1 selects boot ROM region
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- core_req_i  in  1  fetch request
- core_addr_i  in  ADDR_WIDTH  fetch byte address; [1:0] ignored
- core_gnt_o  out  1  request accepted this cycle (combinational)
- core_rvalid_o  out  1  response valid
- core_rdata_o  out  DATA_WIDTH  read data; 0 when rvalid=0
- core_err_o  out  1  response error, only with rvalid
- ld_req_i, ld_we_i  in  1 each  loader request / write enable
- ld_be_i  in  4  byte enables for writes
- ld_addr_i  in  ADDR_WIDTH  loader byte address
- ld_wdata_i  in  DATA_WIDTH  write data
- ld_gnt_o, ld_rvalid_o, ld_err_o  out  1 each  as core port
- ld_rdata_o  out  DATA_WIDTH  read data; 0 when rvalid=0
- rom_en_o  out  1  ROM read strobe, one cycle
- rom_addr_o  out  ROM_ADDR_WIDTH  ROM byte address, held until response
- rom_rdata_i  in  DATA_WIDTH  ROM data, valid ROM_WAIT+1 cycles after rom_en_o, stable until next rom_en_o

## Operation

- Region decode: addr[ADDR_WIDTH-1]=0 selects RAM; =1 selects ROM, offset addr[ADDR_WIDTH-2:0].
- RAM word = addr[ADDR_WIDTH-2:2]. Bank = word[log2(N_BANKS)-1:0]. Row = remaining bits. Each bank is an inferred 1R/1W array with registered read and per-byte write enable.
- Arbitration, per cycle:
  - Both ports request the same RAM bank: loader granted, core_gnt_o=0.
  - Different banks: both granted.
  - N_BANKS=1 makes every simultaneous RAM pair a conflict.
- Loader write to RAM: bytes with be=1 are written. ld_rvalid_o pulses next cycle with rdata 0.
- Loader access to ROM region: granted, no ROM access, write dropped, next-cycle rvalid with ld_err_o=1.
- Core ROM FSM: IDLE -> (granted ROM read) -> WAIT (ROM_WAIT cycles, skipped if 0) -> RESP -> IDLE.
  - In the grant cycle: rom_en_o=1 and rom_addr_o is loaded.
  - In RESP: core_rvalid_o=1 and core_rdata_o=rom_rdata_i.
  - core_gnt_o=0 in WAIT. core_gnt_o is allowed in RESP, so a back-to-back request is accepted.
- ROM offset >= 2^ROM_ADDR_WIDTH: no rom_en_o, response next cycle, core_err_o=1, rdata 0.
- Core writes are not supported; the core port is read-only.
- Reset clears the FSM, the wait counter, the rvalid/err registers and rom_addr_o. Outstanding responses are dropped. Memory contents are preserved.

## Timing

- Reset values: all rvalid/err/rom_en_o = 0, rdata outputs = 0, rom_addr_o = 0, FSM = IDLE. Gnt outputs are 0 while rst=1.
- Gnt is combinational from req/addr/state. There is no gnt-before-req dependency.
- RAM read latency: granted at T -> rvalid at T+1. Full throughput: one request per cycle per port.
- ROM read latency: granted at T -> rvalid at T+1+ROM_WAIT.
- Write-then-read: loader write at T, core read of the same word granted at T+1 returns the new data at T+2.
- A read and a write of the same bank in the same cycle cannot both occur, because conflicts serialise them.
- Loader traffic during core ROM WAIT is unaffected; the ROM path is independent of the banks.
- rst asserted in WAIT: next cycle IDLE, no rvalid, rom_en_o=0.

## Test plan

- Reset, then idle: all outputs 0. Core reads RAM 0x0000 after loader writes 0xDEADBEEF at 0x0000 -> core_rdata_o=0xDEADBEEF one cycle after grant.
- Parallel access (N_BANKS=2): core reads 0x0004 while loader writes 0x0000 in the same cycle -> both gnt=1, both rvalid next cycle.
- Conflict: core and loader both target 0x0008 -> ld_gnt_o=1, core_gnt_o=0. Core is granted the following cycle.
- Byte enables: write 0x11223344 with be=4'b0101 over 0xFFFFFFFF -> readback 0xFF22FF44.
- ROM with ROM_WAIT=2: core reads 0x8010 (ADDR_WIDTH=16) at T -> rom_en_o=1 and rom_addr_o=0x010 at T, core_gnt_o=0 at T+1..T+2, rvalid at T+3 with rom_rdata_i. A second ROM request held from T+1 is granted at T+3.
- Errors and reset: core reads ROM offset 0x1000 -> err=1, rdata 0 next cycle. Loader writes 0x8000 -> ld_err_o=1 next cycle. rst during WAIT -> no rvalid afterwards.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: word-interleaved multi-bank RAM shared by the core fetch
// port and a loader port, plus a wait-state boot ROM path on the core port.
module instr_mem_ctrl #(
  parameter int RAM_SIZE       = 32768,
  parameter int DATA_WIDTH     = 32,
  parameter int N_BANKS        = 2,
  parameter int ROM_ADDR_WIDTH = 12,
  parameter int ROM_WAIT       = 1,
  parameter int ADDR_WIDTH     = $clog2(RAM_SIZE) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      core_req_i,
  input  logic [ADDR_WIDTH-1:0]     core_addr_i,
  output logic                      core_gnt_o,
  output logic                      core_rvalid_o,
  output logic [DATA_WIDTH-1:0]     core_rdata_o,
  output logic                      core_err_o,
  input  logic                      ld_req_i,
  input  logic                      ld_we_i,
  input  logic [3:0]                ld_be_i,
  input  logic [ADDR_WIDTH-1:0]     ld_addr_i,
  input  logic [DATA_WIDTH-1:0]     ld_wdata_i,
  output logic                      ld_gnt_o,
  output logic                      ld_rvalid_o,
  output logic                      ld_err_o,
  output logic [DATA_WIDTH-1:0]     ld_rdata_o,
  output logic                      rom_en_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0]     rom_rdata_i
);

  localparam int WORD_W = ADDR_WIDTH - 3;
  localparam int LOG_NB = $clog2(N_BANKS);
  localparam int BW     = (LOG_NB > 0) ? LOG_NB : 1;
  localparam int ROW_W  = WORD_W - LOG_NB;
  localparam int DEPTH  = 2 ** ROW_W;
  localparam int OFF_W  = ADDR_WIDTH - 1;
  localparam int EXT_W  = (OFF_W > ROM_ADDR_WIDTH) ? OFF_W : ROM_ADDR_WIDTH + 1;
  localparam int N_BYTES = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [2:0] WAIT_INIT = (ROM_WAIT > 0) ? 3'(ROM_WAIT - 1) : 3'd0;

  logic [1:0]              state_reg, state_next;
  logic [2:0]              wait_cnt_reg, wait_cnt_next;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_reg;
  logic                    core_ram_vld_reg, core_err_reg;
  logic                    ld_rd_vld_reg, ld_wr_vld_reg, ld_err_reg;
  logic [BW-1:0]           core_bank_reg, ld_bank_reg;

  logic                    core_is_rom, ld_is_rom;
  logic [WORD_W-1:0]       core_word, ld_word;
  logic [BW-1:0]           core_bank, ld_bank;
  logic [ROW_W-1:0]        core_row, ld_row;
  logic [EXT_W-1:0]        core_off_ext;
  logic                    core_rom_ok, conflict;
  logic                    rom_start, core_rom_err, core_ram_rd, ld_ram;
  logic [DATA_WIDTH-1:0]   bank_rdata [N_BANKS];
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{core_addr_i[1:0], ld_addr_i[1:0]};

  assign core_is_rom = core_addr_i[ADDR_WIDTH-1];
  assign ld_is_rom   = ld_addr_i[ADDR_WIDTH-1];
  assign core_word   = core_addr_i[ADDR_WIDTH-2:2];
  assign ld_word     = ld_addr_i[ADDR_WIDTH-2:2];
  assign core_row    = core_word[WORD_W-1:LOG_NB];
  assign ld_row      = ld_word[WORD_W-1:LOG_NB];

  generate
    if (LOG_NB > 0) begin : g_bank_sel
      assign core_bank = core_word[BW-1:0];
      assign ld_bank   = ld_word[BW-1:0];
    end else begin : g_single_bank
      assign core_bank = '0;
      assign ld_bank   = '0;
    end
  endgenerate

  // ROM offsets beyond the macro size are answered with an error, never forwarded.
  assign core_off_ext = EXT_W'(core_addr_i[OFF_W-1:0]);
  assign core_rom_ok  = (core_off_ext >> ROM_ADDR_WIDTH) == '0;

  assign conflict   = core_req_i & ld_req_i & ~core_is_rom & ~ld_is_rom & (core_bank == ld_bank);
  assign ld_gnt_o   = ld_req_i & ~rst;
  assign core_gnt_o = core_req_i & ~rst & (state_reg != ST_WAIT) & ~conflict;

  assign rom_start    = core_gnt_o & core_is_rom & core_rom_ok;
  assign core_rom_err = core_gnt_o & core_is_rom & ~core_rom_ok;
  assign core_ram_rd  = core_gnt_o & ~core_is_rom;
  assign ld_ram       = ld_gnt_o & ~ld_is_rom;
  assign rom_en_o     = rom_start;
  assign rom_addr_o   = rom_addr_reg;

  generate
    for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
      logic                  ld_sel, core_sel;
      logic [ROW_W-1:0]      row;
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rdata_reg;

      assign ld_sel   = ld_ram & (ld_bank == BW'(gi));
      assign core_sel = core_ram_rd & (core_bank == BW'(gi));
      assign row      = ld_sel ? ld_row : core_row;

      // Arbitration guarantees at most one access per bank per cycle.
      always_ff @(posedge clk) begin
        if (ld_sel && ld_we_i) begin
          for (int b = 0; b < N_BYTES; b++) begin
            if (ld_be_i[b]) mem[row][8*b +: 8] <= ld_wdata_i[8*b +: 8];
          end
        end else if (ld_sel || core_sel) begin
          rdata_reg <= mem[row];
        end
      end

      assign bank_rdata[gi] = rdata_reg;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_WAIT: begin
        if (wait_cnt_reg == 3'd0) state_next = ST_RESP;
        else wait_cnt_next = wait_cnt_reg - 3'd1;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (rom_start) begin
      state_next    = (ROM_WAIT == 0) ? ST_RESP : ST_WAIT;
      wait_cnt_next = WAIT_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      wait_cnt_reg     <= 3'd0;
      rom_addr_reg     <= '0;
      core_ram_vld_reg <= 1'b0;
      core_err_reg     <= 1'b0;
      ld_rd_vld_reg    <= 1'b0;
      ld_wr_vld_reg    <= 1'b0;
      ld_err_reg       <= 1'b0;
      core_bank_reg    <= '0;
      ld_bank_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      wait_cnt_reg     <= wait_cnt_next;
      if (rom_start) rom_addr_reg <= {core_off_ext[ROM_ADDR_WIDTH-1:2], 2'b00};
      core_ram_vld_reg <= core_ram_rd;
      core_err_reg     <= core_rom_err;
      ld_rd_vld_reg    <= ld_ram & ~ld_we_i;
      ld_wr_vld_reg    <= ld_ram & ld_we_i;
      ld_err_reg       <= ld_gnt_o & ld_is_rom;
      core_bank_reg    <= core_bank;
      ld_bank_reg      <= ld_bank;
    end
  end

  assign core_rvalid_o = core_ram_vld_reg | core_err_reg | (state_reg == ST_RESP);
  assign core_err_o    = core_err_reg;
  assign core_rdata_o  = (state_reg == ST_RESP) ? rom_rdata_i :
                         core_ram_vld_reg       ? bank_rdata[core_bank_reg] : '0;

  assign ld_rvalid_o = ld_rd_vld_reg | ld_wr_vld_reg | ld_err_reg;
  assign ld_err_o    = ld_err_reg;
  assign ld_rdata_o  = ld_rd_vld_reg ? bank_rdata[ld_bank_reg] : '0;

endmodule
